// File: rtl/shift_arbiter_pkg.sv
// shift_arbiter_pkg: shared widths, ALU opcodes and request payload type for shift_arbiter.
package shift_arbiter_pkg;
  localparam int DATA_W = 32;
  localparam int SHAMT_W = 5;
  localparam logic [4:0] ALU_OP_SLL = 5'b00011;
  localparam logic [4:0] ALU_OP_SRA = 5'b00100;
  typedef struct packed {
    logic [DATA_W-1:0]  operand;
    logic [SHAMT_W-1:0] shiftamt;
    logic               op;
  } shift_req_t;
  function automatic logic [4:0] alu_op(input logic op);
    return op ? ALU_OP_SRA : ALU_OP_SLL;
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin grant with the priority pointer register.
module rr_arb2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);
  logic prio;
  always_comb begin
    grant[0] = valid[0] && (!valid[1] || !prio);
    grant[1] = valid[1] && (!valid[0] || prio);
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) prio <= 1'b0;
    else if (accept) prio <= grant[0];
endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: two requesters share one 32-bit sll/sra shifter with a registered output stage.
// Define SHIFT_ARBITER_STATS_EN to add saturating grant/stall counters.
module shift_arbiter
  import shift_arbiter_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_operand,
  input  logic [SHAMT_W-1:0] req0_shiftamt,
  input  logic               req0_op,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_operand,
  input  logic [SHAMT_W-1:0] req1_shiftamt,
  input  logic               req1_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_result,
  output logic               out_id
`ifdef SHIFT_ARBITER_STATS_EN
  ,
  output logic [15:0]        stat_grant0,
  output logic [15:0]        stat_grant1,
  output logic [15:0]        stat_stall
`endif
);
  logic [1:0] grant;
  logic take, accept;
  shift_req_t sel;
  logic [4:0] opc;
  logic [DATA_W-1:0] shl, shr, result;
  rr_arb2 u_arb (
    .clock  (clock),
    .reset_n(reset_n),
    .valid  ({req1_valid, req0_valid}),
    .accept (accept),
    .grant  (grant)
  );
  always_comb begin
    take       = !out_valid || out_ready;
    req0_ready = grant[0] && take;
    req1_ready = grant[1] && take;
    accept     = req0_ready || req1_ready;
    sel        = grant[1] ? shift_req_t'{req1_operand, req1_shiftamt, req1_op}
                          : shift_req_t'{req0_operand, req0_shiftamt, req0_op};
    opc        = alu_op(sel.op);
    shl        = sel.operand << sel.shiftamt;
    shr        = DATA_W'($signed(sel.operand) >>> sel.shiftamt);
    result     = opc == ALU_OP_SRA ? shr : shl;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_id     <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_result <= result;
      out_id     <= grant[1];
    end else if (out_ready) out_valid <= 1'b0;
`ifdef SHIFT_ARBITER_STATS_EN
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      stat_grant0 <= '0;
      stat_grant1 <= '0;
      stat_stall  <= '0;
    end else begin
      if (req0_ready && ~&stat_grant0) stat_grant0 <= stat_grant0 + 16'd1;
      if (req1_ready && ~&stat_grant1) stat_grant1 <= stat_grant1 + 16'd1;
      if ((req0_valid || req1_valid) && !accept && ~&stat_stall) stat_stall <= stat_stall + 16'd1;
    end
`endif
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed self-checking bench for shift_arbiter.
module tb_shift_arbiter;
  logic clock = 1'b0, reset_n = 1'b0;
  logic req0_valid = 0, req1_valid = 0, req0_op = 0, req1_op = 0, out_ready = 0;
  logic req0_ready, req1_ready, out_valid, out_id;
  logic [31:0] req0_operand = 0, req1_operand = 0, out_result;
  logic [4:0] req0_shiftamt = 0, req1_shiftamt = 0;
  int errors = 0, checks = 0;
`ifdef SHIFT_ARBITER_STATS_EN
  logic [15:0] stat_grant0, stat_grant1, stat_stall;
`endif
  shift_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_operand(req0_operand),
    .req0_shiftamt(req0_shiftamt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_operand(req1_operand),
    .req1_shiftamt(req1_shiftamt), .req1_op(req1_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_id(out_id)
`ifdef SHIFT_ARBITER_STATS_EN
    , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_stall(stat_stall)
`endif
  );
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req0_valid = 0;
    req1_valid = 0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req0_valid = 0;
    req1_valid = 0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 00000000", out_result); end
    checks++; if (out_id !== 1'b0) begin errors++; $display("FAIL reset_id got %b want 0", out_id); end
    checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", {req1_ready, req0_ready}); end
    reset_n = 1'b1;
  endtask

  task automatic test_port0();
    out_ready = 1;
    req0_valid = 1; req0_operand = 32'h1; req0_shiftamt = 5'd4; req0_op = 0;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL p0_ready got %b want 1", req0_ready); end
    step();
    req0_valid = 0;
    checks++; if ({out_valid, out_id, out_result} !== {1'b1, 1'b0, 32'h10}) begin errors++; $display("FAIL p0_result got v=%b id=%b %h want v=1 id=0 00000010", out_valid, out_id, out_result); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL p0_drain got %b want 0", out_valid); end
  endtask

  task automatic test_port1();
    req1_valid = 1; req1_operand = 32'h8000_0000; req1_shiftamt = 5'd4; req1_op = 1;
    step();
    checks++; if ({out_valid, out_id, out_result} !== {1'b1, 1'b1, 32'hF800_0000}) begin errors++; $display("FAIL p1_sra got v=%b id=%b %h want v=1 id=1 f8000000", out_valid, out_id, out_result); end
    req1_shiftamt = 5'd0;
    step();
    checks++; if (out_result !== 32'h8000_0000) begin errors++; $display("FAIL p1_amt0 got %h want 80000000", out_result); end
    req1_valid = 0;
    step();
  endtask

  task automatic test_shift_edges();
    req0_valid = 1; req0_operand = 32'hFFFF_FFFF; req0_shiftamt = 5'd31; req0_op = 0;
    step();
    checks++; if (out_result !== 32'h8000_0000) begin errors++; $display("FAIL sll31 got %h want 80000000", out_result); end
    req0_operand = 32'h7FFF_FFFF; req0_op = 1;
    step();
    checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL sra31_pos got %h want 00000000", out_result); end
    req0_operand = 32'h8000_0001;
    step();
    checks++; if (out_result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sra31_neg got %h want ffffffff", out_result); end
    req0_valid = 0;
    step();
  endtask

  task automatic test_alternate();
    logic [31:0] exp_r [4];
    exp_r = '{32'h2, 32'hFFF0_0000, 32'h2, 32'hFFF0_0000};
    do_reset();
    out_ready = 1;
    req0_valid = 1; req0_operand = 32'h1; req0_shiftamt = 5'd1; req0_op = 0;
    req1_valid = 1; req1_operand = 32'hF000_0000; req1_shiftamt = 5'd8; req1_op = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({out_valid, out_id, out_result} !== {1'b1, 1'(i % 2), exp_r[i]}) begin
        errors++;
        $display("FAIL alt_%0d got v=%b id=%b %h want v=1 id=%0d %h", i, out_valid, out_id, out_result, i % 2, exp_r[i]);
      end
    end
    req0_valid = 0;
    req1_valid = 0;
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    req0_valid = 1; req0_operand = 32'h3; req0_shiftamt = 5'd2; req0_op = 0;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready got %b want 00", {req1_ready, req0_ready}); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({out_valid, out_id, out_result, req0_ready} !== {1'b1, 1'b1, 32'hFFF0_0000, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold_%0d got v=%b id=%b %h rdy=%b want v=1 id=1 fff00000 rdy=0", i, out_valid, out_id, out_result, req0_ready);
      end
    end
    out_ready = 1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", req0_ready); end
    step();
    checks++; if ({out_valid, out_id, out_result} !== {1'b1, 1'b0, 32'hC}) begin errors++; $display("FAIL bp_overwrite got v=%b id=%b %h want v=1 id=0 0000000c", out_valid, out_id, out_result); end
  endtask

  task automatic test_reset_mid();
    req1_valid = 1;
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre got %b want 1", out_valid); end
    #2;
    reset_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_async got %b want 0", out_valid); end
    #3;
    reset_n = 1;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL mid_prio got %b want 01", {req1_ready, req0_ready}); end
    step();
    checks++; if ({out_valid, out_id} !== 2'b10) begin errors++; $display("FAIL mid_first got v=%b id=%b want v=1 id=0", out_valid, out_id); end
    req0_valid = 0;
    req1_valid = 0;
    step();
  endtask

`ifdef SHIFT_ARBITER_STATS_EN
  task automatic test_stats();
    do_reset();
    out_ready = 1;
    req0_valid = 1;
    repeat (5) step();
    req0_valid = 0;
    req1_valid = 1;
    repeat (3) step();
    out_ready = 0;
    repeat (2) step();
    req1_valid = 0;
    #1;
    checks++; if ({stat_grant0, stat_grant1, stat_stall} !== {16'd5, 16'd3, 16'd2}) begin
      errors++;
      $display("FAIL stats got %0d/%0d/%0d want 5/3/2", stat_grant0, stat_grant1, stat_stall);
    end
    out_ready = 1;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_port0();
    test_port1();
    test_shift_edges();
    test_alternate();
    test_backpressure();
    test_reset_mid();
`ifdef SHIFT_ARBITER_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
